// File: rtl/alu_console_pkg.sv
// rtl/alu_console_pkg.sv - op codes, flag bit indices and hex-to-seven-segment table for alu_console
package alu_console_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_NOR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;

    localparam int FLAG_ZF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_SF = 0;

    typedef enum logic [1:0] {
        DISP_A = 2'd0,
        DISP_B = 2'd1,
        DISP_R = 2'd2,
        DISP_F = 2'd3
    } disp_sel_t;

    // Active-low {dp, g..a}; dp is always off.
    function automatic logic [7:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 8'hC0;
            4'h1: hex2seg = 8'hF9;
            4'h2: hex2seg = 8'hA4;
            4'h3: hex2seg = 8'hB0;
            4'h4: hex2seg = 8'h99;
            4'h5: hex2seg = 8'h92;
            4'h6: hex2seg = 8'h82;
            4'h7: hex2seg = 8'hF8;
            4'h8: hex2seg = 8'h80;
            4'h9: hex2seg = 8'h90;
            4'hA: hex2seg = 8'h88;
            4'hB: hex2seg = 8'h83;
            4'hC: hex2seg = 8'hC6;
            4'hD: hex2seg = 8'hA1;
            4'hE: hex2seg = 8'h86;
            default: hex2seg = 8'h8E;
        endcase
    endfunction

endpackage

// File: rtl/alu_console_seg_scan.sv
// rtl/alu_console_seg_scan.sv - multiplexed seven-segment digit scanner (module seg_scan)
module seg_scan
    import alu_console_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [3:0]    nib;

    always_comb begin
        nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) nib = value[4*i +: 4];
        end
    end

    // an/seg follow idx one cycle later, so both always describe the same digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
            an  <= ~DIGITS'(1);
            seg <= hex2seg(4'h0);
        end else begin
            if (cnt == CW'(SCAN_DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            an  <= ~(DIGITS'(1) << idx);
            seg <= hex2seg(nib);
        end
    end

endmodule

// File: rtl/alu_console.sv
// rtl/alu_console.sv - button-loaded ALU with hex display; ALU_CONSOLE_DEBOUNCE_EN adds button debounce
module alu_console
    import alu_console_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int DB_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   sw,
    input  logic [3:0]         op,
    input  logic               btn_a,
    input  logic               btn_b,
    input  logic               btn_f,
    input  logic [1:0]         disp_sel,
    output logic [3:0]         flags,
    output logic [DIGITS-1:0]  an,
    output logic [7:0]         seg
);

    localparam int SHW = $clog2(WIDTH);
    localparam int DW  = 4 * DIGITS;

    logic [2:0] s1, s2, level, level_q, armed, pulse;
    logic [1:0] settle;

    // A button only arms once the synchroniser has seen it released after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            level_q <= '0;
            armed   <= '0;
            settle  <= '0;
        end else begin
            s1      <= {btn_f, btn_b, btn_a};
            s2      <= s1;
            level_q <= level;
            if (settle != 2'd2) settle <= settle + 1'b1;
            armed   <= armed | ({3{settle == 2'd2}} & ~s2);
        end
    end

`ifdef ALU_CONSOLE_DEBOUNCE_EN
    localparam int DBW = $clog2(DB_CYCLES + 1);
    logic [2:0]     db;
    logic [DBW-1:0] db_cnt [3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                    db[i]     <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign level = db;
`else
    assign level = s2;
`endif

    assign pulse = level & ~level_q & armed;

    logic [WIDTH-1:0] a, b, r;
    logic [WIDTH-1:0] alu_r;
    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   shamt;
    logic             cf, ofl;
    logic [3:0]       flags_next;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        shamt = b[SHW-1:0];
        cf    = 1'b0;
        ofl   = 1'b0;
        case (op)
            OP_AND: alu_r = a & b;
            OP_OR:  alu_r = a | b;
            OP_XOR: alu_r = a ^ b;
            OP_NOR: alu_r = ~(a | b);
            OP_ADD: begin
                alu_r = sum[WIDTH-1:0];
                cf    = sum[WIDTH];
                ofl   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = diff[WIDTH-1:0];
                cf    = diff[WIDTH];
                ofl   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL: alu_r = a << shamt;
            OP_SRL: alu_r = a >> shamt;
            OP_SRA: alu_r = $signed(a) >>> shamt;
            default: alu_r = '0;
        endcase
        flags_next          = '0;
        flags_next[FLAG_ZF] = (alu_r == '0);
        flags_next[FLAG_CF] = cf;
        flags_next[FLAG_OF] = ofl;
        flags_next[FLAG_SF] = alu_r[WIDTH-1];
    end

    // Non-blocking loads mean a same-cycle F pulse computes with the old A/B.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a     <= '0;
            b     <= '0;
            r     <= '0;
            flags <= '0;
        end else begin
            if (pulse[0]) a <= sw;
            if (pulse[1]) b <= sw;
            if (pulse[2]) begin
                r     <= alu_r;
                flags <= flags_next;
            end
        end
    end

    logic [WIDTH-1:0] src;
    logic [DW-1:0]    disp_val;

    always_comb begin
        case (disp_sel_t'(disp_sel))
            DISP_A:  src = a;
            DISP_B:  src = b;
            DISP_R:  src = r;
            default: src = {{(WIDTH-4){1'b0}}, flags};
        endcase
    end

    generate
        if (WIDTH >= DW) begin : g_trunc
            assign disp_val = src[DW-1:0];
        end else begin : g_pad
            assign disp_val = {{(DW-WIDTH){1'b0}}, src};
        end
    endgenerate

    seg_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .value (disp_val),
        .an    (an),
        .seg   (seg)
    );

endmodule
